// File: rtl/phys_reg_free_list_pkg.sv
// Shared sizing, register-index types and wrap-around pointer helpers
// used by the physical register free list.
`timescale 1ns/1ps
package phys_reg_free_list_pkg;

  localparam int unsigned SUPER_SCALAR_WIDTH               = 4;
  localparam int unsigned PHYSICAL_REGISTER_FILE_SIZE      = 128;
  localparam int unsigned ARCHITECTURAL_REGISTER_FILE_SIZE = 64;
  localparam int unsigned LOG_PHYSICAL_REGISTER_FILE_SIZE  = $clog2(PHYSICAL_REGISTER_FILE_SIZE);
  localparam int unsigned FREE_LIST_DEPTH =
    PHYSICAL_REGISTER_FILE_SIZE - ARCHITECTURAL_REGISTER_FILE_SIZE;

  typedef logic [LOG_PHYSICAL_REGISTER_FILE_SIZE-1:0] phys_reg_index_t;
  typedef phys_reg_index_t [SUPER_SCALAR_WIDTH-1:0]   phys_reg_vec_t;

  // (ptr + off) mod depth, valid while ptr < depth and off <= depth
  function automatic int unsigned wrap_add(input int unsigned ptr,
                                           input int unsigned off,
                                           input int unsigned depth);
    int unsigned s;
    s = ptr + off;
    return (s >= depth) ? (s - depth) : s;
  endfunction

  // (a - b) mod depth, valid while a, b < depth
  function automatic int unsigned wrap_sub(input int unsigned a,
                                           input int unsigned b,
                                           input int unsigned depth);
    return (a >= b) ? (a - b) : (a + depth - b);
  endfunction

endpackage

// File: rtl/phys_reg_free_list_popcount_prefix.sv
// Exclusive prefix popcount: prefix[k] = number of set bits below bit k,
// plus the total; used to compact sparse port vectors.
`timescale 1ns/1ps
module phys_reg_free_list_popcount_prefix #(
  parameter int unsigned W     = 4,
  parameter int unsigned CNT_W = $clog2(W + 1)
) (
  input  logic [W-1:0]       vec,
  output logic [W*CNT_W-1:0] prefix,
  output logic [CNT_W-1:0]   total
);

  always_comb begin
    logic [CNT_W-1:0] acc;
    acc    = '0;
    prefix = '0;
    for (int k = 0; k < int'(W); k++) begin
      prefix[k*CNT_W +: CNT_W] = acc;
      acc = acc + CNT_W'(vec[k]);
    end
    total = acc;
  end

endmodule

// File: rtl/phys_reg_free_list.sv
// Circular free list of physical register indices between rename (allocate)
// and retire (free). Optional head checkpointing under FREE_LIST_CHECKPOINT_EN.
`timescale 1ns/1ps
module phys_reg_free_list
  import phys_reg_free_list_pkg::*;
#(
  parameter int unsigned NUM_PHYS = PHYSICAL_REGISTER_FILE_SIZE,
  parameter int unsigned NUM_ARCH = ARCHITECTURAL_REGISTER_FILE_SIZE,
  parameter int unsigned WIDTH    = SUPER_SCALAR_WIDTH,
  localparam int unsigned DEPTH   = NUM_PHYS - NUM_ARCH,
  localparam int unsigned PW      = $clog2(NUM_PHYS),
  localparam int unsigned CW      = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [WIDTH-1:0]    alloc_req,
  output logic                alloc_grant,
  output logic [WIDTH*PW-1:0] alloc_reg,
  input  logic [WIDTH-1:0]    free_valid,
  input  logic [WIDTH*PW-1:0] free_reg,
`ifdef FREE_LIST_CHECKPOINT_EN
  input  logic                ckpt_take,
  input  logic                ckpt_restore,
`endif
  output logic [CW-1:0]       free_count,
  output logic                overflow_err
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned NW = $clog2(WIDTH + 1);
  localparam int unsigned XW = CW + 1;

  logic [PW-1:0]       mem [DEPTH];
  logic [AW-1:0]       head, tail, head_next, tail_next;
  logic [CW-1:0]       count, count_next;
  logic [WIDTH*NW-1:0] a_pre, f_pre;
  logic [NW-1:0]       a_n, f_m;
  logic [XW-1:0]       base, room, m_acc, sum;
  logic [WIDTH-1:0]    f_keep;
  logic                ovf_c;
  logic                restore_c;

  phys_reg_free_list_popcount_prefix #(.W(WIDTH), .CNT_W(NW)) u_alloc_pc (
    .vec    (alloc_req),
    .prefix (a_pre),
    .total  (a_n)
  );

  phys_reg_free_list_popcount_prefix #(.W(WIDTH), .CNT_W(NW)) u_free_pc (
    .vec    (free_valid),
    .prefix (f_pre),
    .total  (f_m)
  );

`ifdef FREE_LIST_CHECKPOINT_EN
  logic [AW-1:0] snap;

  assign restore_c = ckpt_restore;

  // Snapshot captures the post-allocation head; a concurrent restore wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap <= '0;
    end else if (ckpt_take && !ckpt_restore) begin
      snap <= head_next;
    end
  end
`else
  assign restore_c = 1'b0;
`endif

  // All-or-nothing grant against the registered count; restore blocks allocation.
  assign alloc_grant = (XW'(a_n) <= XW'(count)) && !restore_c;

  // Port k reads the entry at head plus the number of requesting ports below it.
  always_comb begin
    alloc_reg = '0;
    for (int k = 0; k < int'(WIDTH); k++) begin
      alloc_reg[k*PW +: PW] =
        mem[AW'(wrap_add(32'(head), 32'(a_pre[k*NW +: NW]), DEPTH))];
    end
  end

  // Next pointers/count; excess frees (highest ports) are dropped on overflow.
  always_comb begin
    base      = XW'(count) - (alloc_grant ? XW'(a_n) : XW'(0));
    head_next = alloc_grant ? AW'(wrap_add(32'(head), 32'(a_n), DEPTH)) : head;
`ifdef FREE_LIST_CHECKPOINT_EN
    if (ckpt_restore) begin
      base      = XW'(count) + XW'(wrap_sub(32'(head), 32'(snap), DEPTH));
      head_next = snap;
    end
`endif
    room      = (base >= XW'(DEPTH)) ? XW'(0) : (XW'(DEPTH) - base);
    ovf_c     = XW'(f_m) > room;
    m_acc     = ovf_c ? room : XW'(f_m);
    sum       = base + m_acc;
    count_next = (sum > XW'(DEPTH)) ? CW'(DEPTH) : CW'(sum);
    tail_next = AW'(wrap_add(32'(tail), 32'(m_acc), DEPTH));
    f_keep    = '0;
    for (int k = 0; k < int'(WIDTH); k++) begin
      f_keep[k] = free_valid[k] && (XW'(f_pre[k*NW +: NW]) < room);
    end
  end

  // Pointer, count, sticky error and entry storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head         <= '0;
      tail         <= '0;
      count        <= CW'(DEPTH);
      overflow_err <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= PW'(NUM_ARCH + 32'(i));
      end
    end else begin
      head  <= head_next;
      tail  <= tail_next;
      count <= count_next;
      if (ovf_c) begin
        overflow_err <= 1'b1;
      end
      for (int k = 0; k < int'(WIDTH); k++) begin
        if (f_keep[k]) begin
          mem[AW'(wrap_add(32'(tail), 32'(f_pre[k*NW +: NW]), DEPTH))] <=
            free_reg[k*PW +: PW];
        end
      end
    end
  end

  assign free_count = count;

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Directed scoreboard bench for phys_reg_free_list; checkpoint scenario runs
// when FREE_LIST_CHECKPOINT_EN is defined.
`timescale 1ns/1ps
module tb_phys_reg_free_list;
  import phys_reg_free_list_pkg::*;

  localparam int unsigned PW = LOG_PHYSICAL_REGISTER_FILE_SIZE;
  localparam int unsigned CW = $clog2(FREE_LIST_DEPTH + 1);

  typedef struct {
    logic          grant;
    logic [3:0]    req;
    phys_reg_vec_t regs;
    logic [CW-1:0] cnt;
    logic          ovf;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic [3:0]    alloc_req;
  logic          alloc_grant;
  phys_reg_vec_t alloc_reg;
  logic [3:0]    free_valid;
  phys_reg_vec_t free_reg;
  logic [CW-1:0] free_count;
  logic          overflow_err;
`ifdef FREE_LIST_CHECKPOINT_EN
  logic          ckpt_take;
  logic          ckpt_restore;
`endif

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  phys_reg_free_list dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .alloc_req    (alloc_req),
    .alloc_grant  (alloc_grant),
    .alloc_reg    (alloc_reg),
    .free_valid   (free_valid),
    .free_reg     (free_reg),
`ifdef FREE_LIST_CHECKPOINT_EN
    .ckpt_take    (ckpt_take),
    .ckpt_restore (ckpt_restore),
`endif
    .free_count   (free_count),
    .overflow_err (overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic phys_reg_vec_t pv(input int a, input int b, input int c, input int d);
    phys_reg_vec_t v;
    v[0] = PW'(a);
    v[1] = PW'(b);
    v[2] = PW'(c);
    v[3] = PW'(d);
    return v;
  endfunction

  // Monitor: one expectation per driven cycle, checked mid-cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_checks++;
      if (alloc_grant !== e.grant) begin
        n_fail++;
        $display("FAIL grant req=%b: got %b want %b", e.req, alloc_grant, e.grant);
      end
      if (e.grant && alloc_grant) begin
        for (int k = 0; k < 4; k++) begin
          if (e.req[k]) begin
            n_checks++;
            if (alloc_reg[k] !== e.regs[k]) begin
              n_fail++;
              $display("FAIL alloc_reg[%0d]: got %0d want %0d", k, alloc_reg[k], e.regs[k]);
            end
          end
        end
      end
      n_checks++;
      if (free_count !== e.cnt) begin
        n_fail++;
        $display("FAIL free_count: got %0d want %0d", free_count, e.cnt);
      end
      n_checks++;
      if (overflow_err !== e.ovf) begin
        n_fail++;
        $display("FAIL overflow_err: got %b want %b", overflow_err, e.ovf);
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] req, input logic [3:0] fv, input phys_reg_vec_t fr,
                       input logic g, input phys_reg_vec_t regs, input int cnt, input logic ovf);
    exp_t e;
    alloc_req  = req;
    free_valid = fv;
    free_reg   = fr;
    e.grant = g;
    e.req   = req;
    e.regs  = regs;
    e.cnt   = CW'(cnt);
    e.ovf   = ovf;
    q.push_back(e);
  endtask

  task automatic step(input logic [3:0] req, input logic [3:0] fv, input phys_reg_vec_t fr,
                      input logic g, input phys_reg_vec_t regs, input int cnt, input logic ovf);
    sync();
    drive(req, fv, fr, g, regs, cnt, ovf);
  endtask

  task automatic do_reset();
    sync();
    alloc_req  = '0;
    free_valid = '0;
    free_reg   = '0;
`ifdef FREE_LIST_CHECKPOINT_EN
    ckpt_take    = 1'b0;
    ckpt_restore = 1'b0;
`endif
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    phys_reg_vec_t z;
    z = pv(0, 0, 0, 0);
    rst_n = 1'b1;
    do_reset();

    // Reset state and full-width allocation
    step(4'b0000, 4'b0000, z, 1'b1, z, 64, 1'b0);
    step(4'b1111, 4'b0000, z, 1'b1, pv(64, 65, 66, 67), 64, 1'b0);
    step(4'b0000, 4'b0000, z, 1'b1, z, 60, 1'b0);

    // Sparse request compaction
    do_reset();
    step(4'b1010, 4'b0000, z, 1'b1, pv(0, 64, 0, 65), 64, 1'b0);
    step(4'b0000, 4'b0000, z, 1'b1, z, 62, 1'b0);

    // Drain to two entries, then too-large and exact-fit requests
    for (int i = 0; i < 15; i++) begin
      step(4'b1111, 4'b0000, z, 1'b1,
           pv(66 + 4*i, 67 + 4*i, 68 + 4*i, 69 + 4*i), 62 - 4*i, 1'b0);
    end
    step(4'b0111, 4'b0000, z, 1'b0, z, 2, 1'b0);
    step(4'b0011, 4'b0000, z, 1'b1, pv(126, 127, 0, 0), 2, 1'b0);
    step(4'b0000, 4'b0000, z, 1'b1, z, 0, 1'b0);

    // Empty list: frees arriving now are only allocatable next cycle
    step(4'b0001, 4'b0101, pv(10, 0, 20, 0), 1'b0, z, 0, 1'b0);
    step(4'b0001, 4'b0000, z, 1'b1, pv(10, 0, 0, 0), 2, 1'b0);
    step(4'b0001, 4'b0000, z, 1'b1, pv(20, 0, 0, 0), 1, 1'b0);
    step(4'b0000, 4'b0000, z, 1'b1, z, 0, 1'b0);

    // Overflow at count 63, sticky until reset; dropped free is port 1
    do_reset();
    step(4'b0001, 4'b0000, z, 1'b1, pv(64, 0, 0, 0), 64, 1'b0);
    step(4'b0000, 4'b0011, pv(64, 65, 0, 0), 1'b1, z, 63, 1'b0);
    step(4'b0000, 4'b0000, z, 1'b1, z, 64, 1'b1);
    step(4'b1111, 4'b0000, z, 1'b1, pv(65, 66, 67, 68), 64, 1'b1);
    step(4'b0011, 4'b1000, pv(0, 0, 0, 99), 1'b1, pv(69, 70, 0, 0), 60, 1'b1);
    step(4'b0000, 4'b0000, z, 1'b1, z, 59, 1'b1);
    do_reset();
    step(4'b0000, 4'b0000, z, 1'b1, z, 64, 1'b0);

`ifdef FREE_LIST_CHECKPOINT_EN
    // Snapshot at head 0, allocate 8, restore reclaims them all
    do_reset();
    sync();
    ckpt_take = 1'b1;
    drive(4'b0000, 4'b0000, z, 1'b1, z, 64, 1'b0);
    sync();
    ckpt_take = 1'b0;
    drive(4'b1111, 4'b0000, z, 1'b1, pv(64, 65, 66, 67), 64, 1'b0);
    step(4'b1111, 4'b0000, z, 1'b1, pv(68, 69, 70, 71), 60, 1'b0);
    sync();
    ckpt_restore = 1'b1;
    drive(4'b1111, 4'b0000, z, 1'b0, z, 56, 1'b0);
    sync();
    ckpt_restore = 1'b0;
    drive(4'b0001, 4'b0000, z, 1'b1, pv(64, 0, 0, 0), 64, 1'b0);
    step(4'b0000, 4'b0000, z, 1'b1, z, 63, 1'b0);
`endif

    sync();
    alloc_req  = '0;
    free_valid = '0;
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard drain: %0d pending want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
